spi_xfer_master: RTL and testbench
==================================

# spi_xfer_master

SPI mode-0 master engine that drives the `sck`/`ss`/`mosi` pins of SPI slave peripherals (the bit-reversal slave and flash-style devices) and captures `miso`. It takes one transfer command (up to 16 bits, programmable clock divider) through a valid/ready request port. It returns the captured bits through a valid/ready response port. It sits between the APB-side SPI register front-end and the SPI pins, in a single clock domain.

## Interface
Parameters:
- `MAX_BITS`, 16: maximum bits per transfer. Sets the width of `req_txdata`/`rsp_rxdata`.
- `DIV_W`, 8: width of the divider field.

Ports:
- `clock`  in  1  system clock; every flop is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  transfer command valid.
- `req_ready`  out  1  engine idle and able to accept a command.
- `req_txdata`  in  16  bits to shift out, right-aligned; `req_txdata[len-1]` is sent first.
- `req_len`  in  5  bit count; 1..16 are used as given, 0 means 16, 17..31 are clamped to 16.
- `req_div`  in  `DIV_W`  half-period of `sck` = `req_div`+1 clock cycles (H).
- `rsp_valid`  out  1  transfer complete; `rsp_rxdata` valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rxdata`  out  16  captured bits, right-aligned; first received bit at [len-1]; bits above len-1 are 0.
- `sck`  out  1  SPI clock; idles at 0 (CPOL=0).
- `ss`  out  1  slave select, active-low; idles at 1.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in.

## Operation
- States: IDLE, SETUP, HIGH, LOW, TAIL, RESP.
- All pin outputs, `rsp_valid` and `rsp_rxdata` are registered.
- `req_ready` = (state==IDLE) && !`reset`.
- IDLE:
  - Accept when `req_valid && req_ready`.
  - Latch txdata, effective len and div.
  - Clear the rx shift register and the bit counter.
  - Next state is SETUP.
- SETUP:
  - `ss`=0, `sck`=0, `mosi`=txdata[len-1].
  - Lasts H cycles, then go to HIGH.
- HIGH:
  - `sck`=1 for H cycles.
  - On the last HIGH cycle, shift `miso` into rx (rx <= {rx, miso}).
  - Increment the bit counter.
  - If counter reaches len, go to TAIL; otherwise go to LOW.
  - In both cases `sck` returns to 0.
- LOW:
  - `sck`=0; `mosi` takes the next bit on the same edge that lowers `sck`.
  - Lasts H cycles, then go to HIGH.
- TAIL:
  - `sck`=0, `ss`=0 for H cycles.
  - Then `ss`=1, `rsp_valid`=1, and go to RESP, all on the same edge.
- RESP:
  - Hold `rsp_valid` and `rsp_rxdata` stable until `rsp_ready`.
  - On the handshake, `rsp_valid` drops and the state returns to IDLE.
  - A new request is not accepted in the handshake cycle itself.
- `mosi` is stable for the entire `sck` high phase. The slave samples on the rising edge.
- `miso` is sampled at the end of the high phase. This captures data a slave updates on the rising edge.
- `req_*` inputs are ignored outside IDLE. Changes to them mid-transfer have no effect.
- `mosi` returns to 0 when entering IDLE.
- Reset values (any state, including mid-transfer):
  - state=IDLE, `sck`=0, `ss`=1, `mosi`=0.
  - `rsp_valid`=0, `rsp_rxdata`=0, `req_ready`=0 while `reset`=1.
  - A transfer cut by reset produces no response.

## Timing
- Let the accept edge be cycle 0.
- `ss` falls at cycle 1.
- Rising edge k (k=0..len-1) of `sck` occurs at cycle 1+H+2kH.
- Falling edge k of `sck` occurs at cycle 1+2H+2kH.
- `ss` rises and `rsp_valid` asserts together at cycle 1+(2·len+1)H.
- Example, div=0, len=16: `ss` low over cycles 1..33, `rsp_valid` at cycle 34.
- With `rsp_ready` held at 1 the handshake occurs in the `rsp_valid` cycle, giving:
  - `req_ready` at cycle 2+(2·len+1)H;
  - back-to-back transfers separated by `ss` high for at least 1 cycle.
- Divider max (div=255): H=256, no overflow. The half-period counter is `DIV_W` bits and compares against the latched div.

## Test plan
- Loopback (`miso`=`mosi`), div=0, len=16, tx=0xA5C3 -> rx=0xA5C3.
  - `ss` low cycles 1..33, 16 `sck` pulses each 1 cycle high, `rsp_valid` at cycle 34.
- Loopback, div=3, len=5, tx=0x0013 -> rx=0x0013.
  - `sck` high/low phases 4 cycles each, first rise at cycle 5.
  - `rsp_valid` at cycle 45.
- len=0 with tx=0x8001, `miso` tied 1 -> 16 pulses, rx=0xFFFF.
  - `mosi` sequence 1,0×14,1.
- Response stall: `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - `rsp_valid`/`rsp_rxdata` stable, `req_ready`=0, a pending `req_valid` is not accepted.
  - On release: accept exactly 1 cycle after the handshake.
- Reset asserted during the 5th HIGH phase.
  - Next cycle: `sck`=0, `ss`=1, `mosi`=0, `rsp_valid`=0, no response ever emitted.
  - After deassert: a new len=8 loopback transfer returns the correct data.
- Slave-model check with `miso` updated on rising `sck`, driving 1,0,1,1,0,0,1,0 -> rx=0x00B2 for len=8.
  - The bench confirms `mosi` never changes while `sck`=1.

Source files
------------

// File: rtl/spi_xfer_master_if.sv
// Request/response bus between the SPI register front-end and the SPI transfer engine.
// The front-end uses the master modport; the engine uses the slave modport.
interface spi_xfer_master_if #(
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned DIV_W    = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_BITS + 1);

    logic                req_valid;
    logic                req_ready;
    logic [MAX_BITS-1:0] req_txdata;
    logic [LEN_W-1:0]    req_len;
    logic [DIV_W-1:0]    req_div;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [MAX_BITS-1:0] rsp_rxdata;

    modport master (
        output req_valid,
        input  req_ready,
        output req_txdata,
        output req_len,
        output req_div,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rxdata
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_txdata,
        input  req_len,
        input  req_div,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rxdata
    );
endinterface

// File: rtl/spi_xfer_master.sv
// SPI mode-0 master: one command of up to MAX_BITS bits per request, MSB first,
// programmable sck half-period, miso captured at the end of each high phase.
module spi_xfer_master #(
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned DIV_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    spi_xfer_master_if.slave  bus,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);
    localparam int unsigned LEN_W = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        TAIL,
        RESP
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    hcnt;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    bitcnt;
    logic [MAX_BITS-1:0] txsr;
    logic [MAX_BITS-1:0] rx;
    logic [MAX_BITS-1:0] rxdata_q;
    logic                rsp_valid_q;

    logic [LEN_W-1:0]    len_eff_c;
    logic [LEN_W-1:0]    shamt_c;
    logic                half_done_c;
    logic                last_bit_c;

    // Length 0 and anything beyond MAX_BITS both mean a full-width transfer.
    always_comb begin
        len_eff_c = bus.req_len;
        if (bus.req_len == LEN_W'(0) || bus.req_len > LEN_W'(MAX_BITS)) begin
            len_eff_c = LEN_W'(MAX_BITS);
        end
        shamt_c     = LEN_W'(MAX_BITS) - len_eff_c;
        half_done_c = (hcnt == div_q);
        last_bit_c  = ((bitcnt + LEN_W'(1)) == len_q);
    end

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rxdata = rxdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            div_q       <= '0;
            hcnt        <= '0;
            len_q       <= '0;
            bitcnt      <= '0;
            txsr        <= '0;
            rx          <= '0;
            rxdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            sck         <= 1'b0;
            ss          <= 1'b1;
            mosi        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        // Left-justify so the first bit to send is always the MSB of txsr.
                        txsr   <= bus.req_txdata << shamt_c;
                        len_q  <= len_eff_c;
                        div_q  <= bus.req_div;
                        rx     <= '0;
                        bitcnt <= '0;
                        hcnt   <= '0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    // First SETUP cycle drops ss; the following H cycles are the setup time.
                    if (ss) begin
                        ss   <= 1'b0;
                        sck  <= 1'b0;
                        mosi <= txsr[MAX_BITS-1];
                    end else if (half_done_c) begin
                        sck   <= 1'b1;
                        hcnt  <= '0;
                        state <= HIGH;
                    end else begin
                        hcnt <= hcnt + DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (half_done_c) begin
                        sck    <= 1'b0;
                        hcnt   <= '0;
                        rx     <= {rx[MAX_BITS-2:0], miso};
                        bitcnt <= bitcnt + LEN_W'(1);
                        if (last_bit_c) begin
                            state <= TAIL;
                        end else begin
                            txsr  <= txsr << 1;
                            mosi  <= txsr[MAX_BITS-2];
                            state <= LOW;
                        end
                    end else begin
                        hcnt <= hcnt + DIV_W'(1);
                    end
                end
                LOW: begin
                    if (half_done_c) begin
                        sck   <= 1'b1;
                        hcnt  <= '0;
                        state <= HIGH;
                    end else begin
                        hcnt <= hcnt + DIV_W'(1);
                    end
                end
                TAIL: begin
                    if (half_done_c) begin
                        ss          <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rxdata_q    <= rx;
                        hcnt        <= '0;
                        state       <= RESP;
                    end else begin
                        hcnt <= hcnt + DIV_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        mosi        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_master.sv
// Directed bench for spi_xfer_master: pin timing, loopback data, response stall,
// reset abort and a rising-edge slave model, all against hand-computed values.
module tb_spi_xfer_master;
    logic       clock = 1'b0;
    logic       reset;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic [1:0] miso_mode;
    logic       slave_bit;
    logic [15:0] spat;

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    int t0, acc_wait, ss_fall, ss_last, first_rise, nrise, hi_samples, hi_chg, t_rsp, aborted;
    logic [15:0] mosi_seq;
    logic [15:0] rx_got;

    spi_xfer_master_if #(.MAX_BITS(16), .DIV_W(8)) bus ();

    spi_xfer_master #(.MAX_BITS(16), .DIV_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .sck   (sck),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // miso source: 0 loopback, 1 tied high, 2 slave model
    assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? 1'b1 : slave_bit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge, monitor pins every negedge until rsp_valid.
    task automatic do_xfer(input logic [15:0] tx, input logic [4:0] len, input logic [7:0] div,
                           input int stall, input int rst_rise);
        int   waited;
        int   rel;
        int   budget;
        int   bad;
        logic prev_sck;
        logic prev_mosi;
        logic done;
        ss_fall = -1; ss_last = -1; first_rise = -1; nrise = 0; hi_samples = 0;
        hi_chg = 0; t_rsp = -1; aborted = 0; mosi_seq = '0; rx_got = '0; slave_bit = 1'b0;
        bus.req_txdata = tx;
        bus.req_len    = len;
        bus.req_div    = div;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = (stall == 0);
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'(waited), 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        acc_wait  = waited;
        t0        = cyc + 1;
        prev_sck  = sck;
        prev_mosi = mosi;
        @(negedge clock);
        // Scramble the request mid-transfer; the engine must ignore it.
        bus.req_valid  = 1'b0;
        bus.req_txdata = ~tx;
        bus.req_len    = 5'd3;
        bus.req_div    = 8'd7;
        budget = 0;
        done   = 1'b0;
        while (!done && budget < 20000) begin
            rel = cyc - t0;
            if (!ss && ss_fall < 0) ss_fall = rel;
            if (!ss) ss_last = rel;
            if (sck) begin
                hi_samples++;
                if (mosi !== prev_mosi) hi_chg++;
            end
            if (sck && !prev_sck) begin
                if (first_rise < 0) first_rise = rel;
                mosi_seq  = {mosi_seq[14:0], mosi};
                nrise++;
                slave_bit = spat[15];
                spat      = {spat[14:0], 1'b0};
                if (rst_rise != 0 && nrise == rst_rise) begin
                    reset   = 1'b1;
                    aborted = 1;
                    done    = 1'b1;
                end
            end
            if (!done && bus.rsp_valid) begin
                t_rsp  = rel;
                rx_got = bus.rsp_rxdata;
                done   = 1'b1;
            end
            prev_sck  = sck;
            prev_mosi = mosi;
            if (!done) begin
                @(negedge clock);
                budget++;
            end
        end
        if (!done) begin
            check("rsp_timeout", 32'(budget), 32'd0);
            return;
        end
        if (aborted != 0) return;
        if (stall > 0) begin
            bus.req_txdata = tx;
            bus.req_len    = len;
            bus.req_div    = div;
            bus.req_valid  = 1'b1;
            bad = 0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clock);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rxdata !== rx_got ||
                    bus.req_ready !== 1'b0 || ss !== 1'b1) bad++;
            end
            check("stall_hold", 32'(bad), 32'd0);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clock);
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("ready_after_hs", 32'(bus.req_ready), 32'd1);
        check("mosi_idle", 32'(mosi), 32'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_txdata = '0; bus.req_len = '0; bus.req_div = '0;
        bus.rsp_ready = 1'b1;
        miso_mode = 2'd0; spat = '0; slave_bit = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rxdata", 32'(bus.rsp_rxdata), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Loopback, div=0, len=16
        do_xfer(16'hA5C3, 5'd16, 8'd0, 0, 0);
        check("t1_rx", 32'(rx_got), 32'hA5C3);
        check("t1_ss_fall", 32'(ss_fall), 32'd1);
        check("t1_ss_last", 32'(ss_last), 32'd33);
        check("t1_first_rise", 32'(first_rise), 32'd2);
        check("t1_pulses", 32'(nrise), 32'd16);
        check("t1_hi_cycles", 32'(hi_samples), 32'd16);
        check("t1_rsp_cycle", 32'(t_rsp), 32'd34);
        check("t1_mosi_seq", 32'(mosi_seq), 32'hA5C3);
        check("t1_mosi_hi", 32'(hi_chg), 32'd0);

        // Loopback, div=3, len=5
        do_xfer(16'h0013, 5'd5, 8'd3, 0, 0);
        check("t2_rx", 32'(rx_got), 32'h0013);
        check("t2_first_rise", 32'(first_rise), 32'd5);
        check("t2_hi_cycles", 32'(hi_samples), 32'd20);
        check("t2_pulses", 32'(nrise), 32'd5);
        check("t2_rsp_cycle", 32'(t_rsp), 32'd45);
        check("t2_ss_last", 32'(ss_last), 32'd44);
        check("t2_mosi_hi", 32'(hi_chg), 32'd0);

        // len=0 means 16 bits; miso tied high
        miso_mode = 2'd1;
        do_xfer(16'h8001, 5'd0, 8'd1, 0, 0);
        check("t3_rx", 32'(rx_got), 32'hFFFF);
        check("t3_pulses", 32'(nrise), 32'd16);
        check("t3_mosi_seq", 32'(mosi_seq), 32'h8001);
        check("t3_rsp_cycle", 32'(t_rsp), 32'd67);
        check("t3_first_rise", 32'(first_rise), 32'd3);

        // Clamp: len=20 behaves as 16
        miso_mode = 2'd0;
        do_xfer(16'h3C96, 5'd20, 8'd0, 0, 0);
        check("t3b_rx", 32'(rx_got), 32'h3C96);
        check("t3b_pulses", 32'(nrise), 32'd16);

        // Response stall for 10 cycles with a pending request
        do_xfer(16'h000A, 5'd4, 8'd0, 10, 0);
        check("t4_rx", 32'(rx_got), 32'h000A);
        check("t4_rsp_cycle", 32'(t_rsp), 32'd10);
        do_xfer(16'h000A, 5'd4, 8'd0, 0, 0);
        check("t4_accept_wait", 32'(acc_wait), 32'd0);
        check("t4_rx2", 32'(rx_got), 32'h000A);
        check("t4_ss_fall2", 32'(ss_fall), 32'd1);

        // Reset during the 5th high phase
        do_xfer(16'h00C5, 5'd8, 8'd1, 0, 5);
        check("t5_aborted", 32'(aborted), 32'd1);
        @(negedge clock);
        check("t5_sck", 32'(sck), 32'd0);
        check("t5_ss", 32'(ss), 32'd1);
        check("t5_mosi", 32'(mosi), 32'd0);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.rsp_valid !== 1'b0 || ss !== 1'b1 || bus.req_ready !== 1'b1) bad++;
        end
        check("t5_no_rsp", 32'(bad), 32'd0);
        do_xfer(16'h005A, 5'd8, 8'd0, 0, 0);
        check("t5_rx_after", 32'(rx_got), 32'h005A);
        check("t5_rsp_cycle", 32'(t_rsp), 32'd18);

        // Slave updating miso on rising sck: 1,0,1,1,0,0,1,0
        miso_mode = 2'd2;
        spat = 16'hB200;
        do_xfer(16'h003C, 5'd8, 8'd2, 0, 0);
        check("t6_rx", 32'(rx_got), 32'h00B2);
        check("t6_mosi_seq", 32'(mosi_seq), 32'h003C);
        check("t6_mosi_hi", 32'(hi_chg), 32'd0);
        check("t6_first_rise", 32'(first_rise), 32'd4);
        check("t6_rsp_cycle", 32'(t_rsp), 32'd52);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d limit=50000", cyc);
        $fatal(1, "watchdog");
    end
endmodule
